fir_out_requant: RTL and testbench
==================================

// Module: fir_out_requant
// PURPOSE
//   Output stage on the far side of the 3-tap FIR filter.
//   - Accepts the filter's 16-bit signed result and its overflow flag.
//   - Rounds and saturates each sample to 8 bits.
//   - Buffers samples in a small FIFO and presents them on a valid/ready stream.
//   - Keeps saturating statistics counters for overflow events and dropped samples.
// PARAMETERS
//   IN_W   16  input sample width (signed)
//   OUT_W  8   output sample width (signed)
//   SHIFT  7   arithmetic right shift applied before saturation (>=1)
//   DEPTH  4   FIFO depth in entries (power of two, >=2)
//   CNT_W  16  width of statistics counters
// PORTS
//   clk        in   1      clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      in_data holds a new sample this cycle (no backpressure)
//   in_data    in   IN_W   signed filter output
//   in_ovf     in   1      filter overflow flag, sampled every cycle
//   out_valid  out  1      out_data/out_sat hold a buffered sample
//   out_ready  in   1      consumer accepts the sample this cycle
//   out_data   out  OUT_W  signed requantised sample
//   out_sat    out  1      1 = the sample was clipped by saturation
//   ovf_count  out  CNT_W  count of in_ovf rising edges, saturating
//   drop_count out  CNT_W  count of samples lost to a full FIFO, saturating
//   clr_stats  in   1      synchronous clear of both counters
// BEHAVIOUR
//   Reset (async, rst=1)
//     - All outputs 0; FIFO empty; stage register invalid; in_ovf history register = 0.
//   Requantisation (stage 1, registered)
//     - t = (in_data + 2^(SHIFT-1)) >>> SHIFT, computed in IN_W+1 bits (no wrap).
//     - Rounding is round-half-up; the arithmetic shift floors negative values.
//     - If t > 2^(OUT_W-1)-1: out = max, sat = 1.
//     - If t < -2^(OUT_W-1): out = min, sat = 1.
//     - Otherwise: out = t[OUT_W-1:0], sat = 0.
//   Latency
//     - in_valid in cycle N: stage register valid in cycle N+1.
//     - FIFO write occurs on the edge ending cycle N+1.
//     - With the FIFO empty, out_valid = 1 in cycle N+2.
//   FIFO (show-ahead)
//     - out_data and out_sat always reflect the head entry.
//     - out_valid = !empty.
//     - Pop on out_valid & out_ready.
//     - While out_valid & !out_ready, out_data and out_sat are held stable.
//     - Pointers wrap modulo DEPTH. Full and empty are distinguished by one extra pointer bit.
//   Full and drop rules
//     - Write while full with no pop in the same cycle: the sample is discarded and
//       drop_count increments. FIFO contents are unchanged.
//     - Write and pop in the same cycle while full: both happen. No drop; occupancy stays DEPTH.
//     - Write and pop in the same cycle while empty: not possible, because out_valid = 0.
//   ovf_count
//     - Increments when in_ovf = 1 and the previous cycle's in_ovf = 0.
//     - Independent of in_valid.
//   Counters
//     - Saturate at 2^CNT_W-1.
//     - clr_stats zeroes both counters on the next edge.
//     - If clr_stats coincides with an increment event, clear wins (result 0).
//   Throughput
//     - One sample per cycle sustained while out_ready = 1. No bubbles.
//   Reset mid-operation
//     - FIFO contents and any in-flight stage sample are discarded.
//     - out_valid drops immediately (asynchronously).
// TESTING
//   1 Rounding: SHIFT=7.
//     - in_data = 64 -> out_data = 1, out_sat = 0.
//     - in_data = -64 -> out_data = 0.
//     - in_data = -65 -> out_data = -1.
//   2 Saturation:
//     - in_data = 16383 -> out_data = 127, out_sat = 1.
//     - in_data = -32768 -> out_data = -128, out_sat = 1.
//     - in_data = 16256 -> out_data = 127, out_sat = 0.
//   3 Latency and streaming: out_ready = 1, in_valid on 10 consecutive cycles
//     -> out_valid first seen 2 cycles after the first in_valid.
//     -> 10 samples out, in order, no gaps.
//   4 Backpressure: out_ready = 0, 6 samples in (DEPTH = 4)
//     -> 4 held in the FIFO, drop_count = 1 (stage holds the 5th).
//     -> Then out_ready = 1: samples 1-4 and 5 emerge in order.
//   5 Full with simultaneous pop: FIFO full, in_valid = 1 and out_ready = 1 in the same cycle
//     -> no drop; occupancy stays 4.
//   6 Statistics: in_ovf pattern 0,1,1,0,1 -> ovf_count = 2.
//     - clr_stats coincident with an in_ovf rising edge -> ovf_count = 0.
//     - Reset while out_valid = 1 -> out_valid = 0 and all counters 0.

Source files
------------

// File: rtl/fir_out_requant.sv
// ============================================================================
// Module   : fir_out_requant
// Function : FIR output stage. Rounds and saturates to OUT_W bits, buffers
//            samples in a show-ahead FIFO, keeps overflow and drop counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_out_requant #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 7,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_ovf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat,
  output logic [CNT_W-1:0]        ovf_count,
  output logic [CNT_W-1:0]        drop_count,
  input  logic                    clr_stats
);

  localparam int                    c_AW        = $clog2(DEPTH);
  localparam logic signed [IN_W:0]  c_RND       = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_W:0]  c_MAX       = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0]  c_MIN       = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]      c_OUT_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]      c_OUT_MIN   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]      c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      c_CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [c_AW:0]         c_PTR_ONE   = {{c_AW{1'b0}}, 1'b1};

  // Requantisation datapath (one extra bit so the rounding add never wraps)
  logic signed [IN_W:0]  w_sum;
  logic signed [IN_W:0]  w_shift;
  logic [OUT_W-1:0]      w_q_data;
  logic                  w_q_sat;

  assign w_sum   = $signed({in_data[IN_W-1], in_data}) + c_RND;
  assign w_shift = w_sum >>> SHIFT;

  always_comb begin
    w_q_data = w_shift[OUT_W-1:0];
    w_q_sat  = 1'b0;
    if (w_shift > c_MAX) begin
      w_q_data = c_OUT_MAX;
      w_q_sat  = 1'b1;
    end else if (w_shift < c_MIN) begin
      w_q_data = c_OUT_MIN;
      w_q_sat  = 1'b1;
    end
  end

  // Stage register and FIFO state
  logic                  r_stg_vld;
  logic [OUT_W-1:0]      r_stg_data;
  logic                  r_stg_sat;
  logic [OUT_W:0]        r_mem [DEPTH];
  logic [c_AW:0]         r_wr_ptr;
  logic [c_AW:0]         r_rd_ptr;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_stg_free;
  logic                  w_drop;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_pop      = !w_empty && out_ready;
  assign w_push     = r_stg_vld && (!w_full || w_pop);
  // A blocked stage sample is kept; the newly arriving sample is the one lost.
  assign w_stg_free = !r_stg_vld || w_push;
  assign w_drop     = in_valid && !w_stg_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_vld  <= 1'b0;
      r_stg_data <= '0;
      r_stg_sat  <= 1'b0;
    end else if (w_stg_free) begin
      r_stg_vld  <= in_valid;
      if (in_valid) begin
        r_stg_data <= w_q_data;
        r_stg_sat  <= w_q_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[c_AW-1:0]] <= {r_stg_sat, r_stg_data};
        r_wr_ptr                  <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = $signed(r_mem[r_rd_ptr[c_AW-1:0]][OUT_W-1:0]);
  assign out_sat   = r_mem[r_rd_ptr[c_AW-1:0]][OUT_W];

  // Statistics counters
  logic                  r_ovf_d;
  logic [CNT_W-1:0]      r_ovf_cnt;
  logic [CNT_W-1:0]      r_drop_cnt;
  logic                  w_ovf_rise;

  assign w_ovf_rise = in_ovf && !r_ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_d    <= 1'b0;
      r_ovf_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_ovf_d <= in_ovf;
      if (clr_stats) begin
        r_ovf_cnt  <= '0;
        r_drop_cnt <= '0;
      end else begin
        if (w_ovf_rise && (r_ovf_cnt != c_CNT_MAX)) begin
          r_ovf_cnt <= r_ovf_cnt + c_CNT_ONE;
        end
        if (w_drop && (r_drop_cnt != c_CNT_MAX)) begin
          r_drop_cnt <= r_drop_cnt + c_CNT_ONE;
        end
      end
    end
  end

  assign ovf_count  = r_ovf_cnt;
  assign drop_count = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fir_out_requant.sv
// ============================================================================
// Module   : tb_fir_out_requant
// Function : Directed self-checking bench for fir_out_requant.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fir_out_requant;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic signed [15:0]  in_data;
  logic                in_ovf;
  logic                out_valid;
  logic                out_ready;
  logic signed [7:0]   out_data;
  logic                out_sat;
  logic [15:0]         ovf_count;
  logic [15:0]         drop_count;
  logic                clr_stats;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_out_requant #(
    .IN_W(16), .OUT_W(8), .SHIFT(7), .DEPTH(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ovf(in_ovf), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .ovf_count(ovf_count),
    .drop_count(drop_count), .clr_stats(clr_stats)
  );

  typedef struct {
    logic signed [15:0] din;
    int                 exp_data;
    logic               exp_sat;
  } vec_t;

  vec_t vecs[12];
  int   got[16];
  int   n;
  int   first;
  int   last;

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Collect up to 'cycles' cycles of output with out_ready held high.
  task automatic collect(input int cycles);
    n = 0;
    out_ready = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (out_valid && n < 16) begin
        got[n] = out_data;
        n++;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{16'sd64,     1,    1'b0};
    vecs[1]  = '{-16'sd64,    0,    1'b0};
    vecs[2]  = '{-16'sd65,    -1,   1'b0};
    vecs[3]  = '{16'sd16383,  127,  1'b1};
    vecs[4]  = '{-16'sd32768, -128, 1'b1};
    vecs[5]  = '{16'sd16256,  127,  1'b0};
    vecs[6]  = '{16'sd63,     0,    1'b0};
    vecs[7]  = '{16'sd16319,  127,  1'b0};
    vecs[8]  = '{16'sd16320,  127,  1'b1};
    vecs[9]  = '{-16'sd16448, -128, 1'b0};
    vecs[10] = '{-16'sd16449, -128, 1'b1};
    vecs[11] = '{16'sd0,      0,    1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ovf = 1'b0;
    out_ready = 1'b0; clr_stats = 1'b0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_ovf", ovf_count, 0);
    chk("rst_drop", drop_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Rounding and saturation vectors, one sample at a time
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = vecs[i].din;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("vec_early_valid", out_valid, 0);
      tick();
      @(negedge clk);
      chk("vec_valid", out_valid, 1);
      chk("vec_data", out_data, vecs[i].exp_data);
      chk("vec_sat", out_sat, vecs[i].exp_sat);
      tick();
    end

    // Streaming: 10 back-to-back samples, expected 1..10 with no gaps
    first = -1; last = -1; n = 0;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 10);
      in_data  = 16'((c + 1) * 128);
      @(negedge clk);
      if (out_valid && n < 16) begin
        if (first < 0) first = c;
        got[n] = out_data;
        n++;
        last = c;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("stream_first", first, 2);
    chk("stream_count", n, 10);
    chk("stream_last", last, 11);
    for (int i = 0; i < 10; i++) chk("stream_data", got[i], i + 1);

    // Backpressure: 6 samples (11..16) into a stalled stream
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_data = 16'((c + 11) * 128);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_valid", out_valid, 1);
    chk("bp_head", out_data, 11);
    chk("bp_drop", drop_count, 1);
    tick(); tick();
    @(negedge clk);
    chk("bp_drop_hold", drop_count, 1);
    tick();
    collect(8);
    chk("bp_count", n, 5);
    for (int i = 0; i < 5; i++) chk("bp_data", got[i], 11 + i);

    // Full FIFO with simultaneous write and pop
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = 16'((c + 21) * 128);
      tick();
    end
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 16'(26 * 128); out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("full_pop_drop", drop_count, 1);
    chk("full_pop_head", out_data, 22);
    tick();
    in_valid = 1'b1; in_data = 16'(27 * 128);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_again_drop", drop_count, 2);
    tick();
    collect(8);
    chk("full_count", n, 5);
    for (int i = 0; i < 5; i++) chk("full_data", got[i], 22 + i);

    // Statistics
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    @(negedge clk);
    chk("clr_drop", drop_count, 0);
    chk("clr_ovf", ovf_count, 0);
    tick();
    in_ovf = 1'b0; tick();
    in_ovf = 1'b1; tick();
    in_ovf = 1'b1; tick();
    in_ovf = 1'b0; tick();
    in_ovf = 1'b1; tick();
    @(negedge clk);
    chk("ovf_pattern", ovf_count, 2);
    tick();
    in_ovf = 1'b0; tick();
    in_ovf = 1'b1; clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    @(negedge clk);
    chk("ovf_clr_wins", ovf_count, 0);
    tick();
    @(negedge clk);
    chk("ovf_level_hold", ovf_count, 0);
    tick();
    in_ovf = 1'b0; tick();
    in_ovf = 1'b1; tick();
    in_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_after_clr", ovf_count, 1);
    tick();

    // Asynchronous reset while data is buffered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'(30 * 128);
    tick();
    in_valid = 1'b1; in_data = 16'(31 * 128);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_ovf", ovf_count, 0);
    chk("mid_rst_drop", drop_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
